// File: rtl/timer_ctrl.sv
// timer_ctrl: Avalon-MM control block that sequences an external timer.
//   clk, rst_n            single clock, asynchronous active-low reset
//   address/write/read    Avalon-MM word address and strobes (never both high)
//   writedata/readdata    Avalon-MM data; readdata is registered
//   tmr_enable            count enable, high only in RUN
//   tmr_borra_irq         one-cycle clear of the timer wrap flag
//   tmr_fin_cuenta        terminal count loaded from the PERIOD shadow
//   tmr_threshold         compare value, written directly via THRESHOLD
//   tmr_irq, tmr_count    timer wrap flag (sticky) and live count
//   irq                   CPU interrupt = STATUS.TO & CTRL.IE
module timer_ctrl #(
    parameter logic [31:0] DEFAULT_PERIOD    = 32'd49999,
    parameter logic [31:0] DEFAULT_THRESHOLD = 32'd24999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  address,
    input  logic        write,
    input  logic        read,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        tmr_enable,
    output logic        tmr_borra_irq,
    output logic [31:0] tmr_fin_cuenta,
    output logic [31:0] tmr_threshold,
    input  logic        tmr_irq,
    input  logic [31:0] tmr_count,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic        en_q, en_d, oneshot_q, oneshot_d, ie_q, ie_d;
    logic        to_q, to_d, ovr_q, ovr_d, borra_q, borra_d;
    logic [31:0] shadow_q, shadow_d, fin_q, fin_d, thr_q, thr_d, rdata_q, rdata_d;
    logic        wr_ctrl, wr_period, wr_thr, wr_status, ev, w1c_to, w1c_ovr;
    assign wr_ctrl   = write && address == 3'd0;
    assign wr_period = write && address == 3'd1;
    assign wr_thr    = write && address == 3'd2;
    assign wr_status = write && address == 3'd3;
    assign w1c_to    = wr_status && writedata[0];
    assign w1c_ovr   = wr_status && writedata[2];
    // A wrap flag still high during our own clear pulse is the same wrap, not a new one.
    assign ev        = tmr_irq && !borra_q;
    always_comb begin
        en_d      = wr_ctrl ? writedata[0] : en_q;
        oneshot_d = wr_ctrl ? writedata[1] : oneshot_q;
        ie_d      = wr_ctrl ? writedata[2] : ie_q;
        state_d   = state_q;
        case (state_q)
            IDLE: state_d = en_d ? RUN : IDLE;
            RUN: begin
                if (ev && oneshot_q) begin
                    state_d = DONE;
                    en_d    = 1'b0;
                end else if (!en_d) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Shadow is sampled before any same-edge PERIOD write lands in it.
        fin_d    = (ev || (state_q == IDLE && state_d == RUN)) ? shadow_q : fin_q;
        shadow_d = wr_period ? writedata : shadow_q;
        thr_d    = wr_thr ? writedata : thr_q;
        to_d     = ev || (to_q && !w1c_to);
        // An event racing a TO clear leaves OVR alone; otherwise a repeat event sets it.
        ovr_d    = (ev && w1c_to) ? ovr_q : (ev && to_q) ? 1'b1 : ovr_q && !w1c_ovr;
        borra_d  = ev;
        rdata_d  = rdata_q;
        if (read) begin
            case (address)
                3'd0:    rdata_d = {29'd0, ie_q, oneshot_q, en_q};
                3'd1:    rdata_d = shadow_q;
                3'd2:    rdata_d = thr_q;
                3'd3:    rdata_d = {29'd0, ovr_q, state_q == RUN, to_q};
                3'd4:    rdata_d = tmr_count;
                default: rdata_d = 32'd0;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            ie_q      <= 1'b0;
            to_q      <= 1'b0;
            ovr_q     <= 1'b0;
            borra_q   <= 1'b0;
            shadow_q  <= DEFAULT_PERIOD;
            fin_q     <= DEFAULT_PERIOD;
            thr_q     <= DEFAULT_THRESHOLD;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            ie_q      <= ie_d;
            to_q      <= to_d;
            ovr_q     <= ovr_d;
            borra_q   <= borra_d;
            shadow_q  <= shadow_d;
            fin_q     <= fin_d;
            thr_q     <= thr_d;
            rdata_q   <= rdata_d;
        end
    end
    assign tmr_enable     = state_q == RUN;
    assign tmr_borra_irq  = borra_q;
    assign tmr_fin_cuenta = fin_q;
    assign tmr_threshold  = thr_q;
    assign readdata       = rdata_q;
    assign irq            = to_q && ie_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: self-checking bench for timer_ctrl with a behavioural timer.
module tb_timer_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata, tmr_fin_cuenta, tmr_threshold, tmr_count;
    logic        tmr_enable, tmr_borra_irq, tmr_irq, irq;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    string       nm_q[$];

    timer_ctrl dut (
        .clk(clk), .rst_n(rst_n), .address(address), .write(write), .read(read),
        .writedata(writedata), .readdata(readdata), .tmr_enable(tmr_enable),
        .tmr_borra_irq(tmr_borra_irq), .tmr_fin_cuenta(tmr_fin_cuenta),
        .tmr_threshold(tmr_threshold), .tmr_irq(tmr_irq), .tmr_count(tmr_count), .irq(irq)
    );

    always #5 clk = ~clk;

    // Timer: counts 0..fin while enabled, wraps to 0 and raises a sticky flag.
    logic [31:0] m_cnt;
    logic        m_irq, m_wrap;
    assign m_wrap    = tmr_enable && m_cnt >= tmr_fin_cuenta;
    assign tmr_count = m_cnt;
    assign tmr_irq   = m_irq;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 32'd0;
            m_irq <= 1'b0;
        end else begin
            m_cnt <= !tmr_enable ? m_cnt : m_wrap ? 32'd0 : m_cnt + 32'd1;
            m_irq <= m_wrap || (m_irq && !tmr_borra_irq);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0; write = 1'b0; read = 1'b0; address = 3'd0; writedata = 32'd0;
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        tick;
        write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
        logic [31:0] x;
        string       s;
        address = a; read = 1'b1;
        exp_q.push_back(e);
        nm_q.push_back(n);
        tick;
        read = 1'b0;
        x = exp_q.pop_front();
        s = nm_q.pop_front();
        checks++;
        if (readdata !== x) begin errors++; $display("FAIL %s: readdata=%0h expected %0h", s, readdata, x); end
    endtask

    task automatic wait_sig(input bit borra, output int n);
        for (n = 1; n <= 300; n++) begin
            tick;
            if (borra ? tmr_borra_irq : tmr_irq) break;
        end
        checks++;
        if (n > 300) begin errors++; $display("FAIL wait_%s: timed out after %0d cycles", borra ? "borra" : "irq", n - 1); end
    endtask

    task automatic test_reset;
        apply_reset;
        checks++; if (tmr_enable !== 1'b0) begin errors++; $display("FAIL rst_enable: got %0b want 0", tmr_enable); end
        checks++; if (tmr_borra_irq !== 1'b0) begin errors++; $display("FAIL rst_borra: got %0b want 0", tmr_borra_irq); end
        checks++; if (tmr_fin_cuenta !== 32'd49999) begin errors++; $display("FAIL rst_fin: got %0d want 49999", tmr_fin_cuenta); end
        checks++; if (tmr_threshold !== 32'd24999) begin errors++; $display("FAIL rst_thr: got %0d want 24999", tmr_threshold); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %0b want 0", irq); end
        checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL rst_readdata: got %0h want 0", readdata); end
        rd(3'd0, 32'd0, "rst_ctrl");
        rd(3'd1, 32'd49999, "rst_period");
        rd(3'd2, 32'd24999, "rst_threshold");
        rd(3'd3, 32'd0, "rst_status");
    endtask

    task automatic test_basic;
        int n;
        apply_reset;
        wr(3'd1, 32'd4);
        checks++; if (tmr_fin_cuenta !== 32'd49999) begin errors++; $display("FAIL fin_shadow_only: got %0d want 49999", tmr_fin_cuenta); end
        wr(3'd0, 32'd5);
        checks++; if (tmr_enable !== 1'b1) begin errors++; $display("FAIL enable_next: got %0b want 1", tmr_enable); end
        checks++; if (tmr_fin_cuenta !== 32'd4) begin errors++; $display("FAIL fin_on_start: got %0d want 4", tmr_fin_cuenta); end
        wait_sig(1'b0, n);
        checks++; if (n !== 5) begin errors++; $display("FAIL irq_latency: got %0d want 5", n); end
        tick;
        checks++; if (tmr_borra_irq !== 1'b1) begin errors++; $display("FAIL borra_pulse: got %0b want 1", tmr_borra_irq); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %0b want 1", irq); end
        tick;
        checks++; if (tmr_borra_irq !== 1'b0) begin errors++; $display("FAIL borra_one_cycle: got %0b want 0", tmr_borra_irq); end
        rd(3'd3, 32'd3, "status_to_run");
    endtask

    task automatic test_ovr;
        int n;
        logic [31:0] frz;
        wait_sig(1'b1, n);
        rd(3'd3, 32'd7, "status_ovr");
        wr(3'd0, 32'd4);
        wr(3'd3, 32'd5);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %0b want 0", irq); end
        checks++; if (tmr_enable !== 1'b0) begin errors++; $display("FAIL enable_off: got %0b want 0", tmr_enable); end
        rd(3'd3, 32'd0, "status_cleared");
        rd(3'd0, 32'd4, "ctrl_ie_only");
        frz = tmr_count;
        repeat (3) tick;
        rd(3'd4, frz, "count_frozen");
    endtask

    task automatic test_oneshot;
        int n;
        apply_reset;
        wr(3'd1, 32'd2);
        wr(3'd0, 32'd3);
        wait_sig(1'b0, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL oneshot_latency: got %0d want 3", n); end
        tick;
        checks++; if (tmr_enable !== 1'b0) begin errors++; $display("FAIL oneshot_done: got %0b want 0", tmr_enable); end
        tick;
        rd(3'd0, 32'd2, "ctrl_en_cleared");
        rd(3'd3, 32'd1, "status_oneshot");
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %0b want 0", irq); end
    endtask

    task automatic test_period_update;
        int n;
        apply_reset;
        wr(3'd1, 32'd4);
        wr(3'd0, 32'd1);
        wr(3'd1, 32'd9);
        checks++; if (tmr_fin_cuenta !== 32'd4) begin errors++; $display("FAIL fin_hold: got %0d want 4", tmr_fin_cuenta); end
        wait_sig(1'b1, n);
        checks++; if (tmr_fin_cuenta !== 32'd9) begin errors++; $display("FAIL fin_reload: got %0d want 9", tmr_fin_cuenta); end
        wr(3'd1, 32'd6);
        wait_sig(1'b0, n);
        wr(3'd1, 32'd12);
        checks++; if (tmr_borra_irq !== 1'b1) begin errors++; $display("FAIL coincide_event: got %0b want 1", tmr_borra_irq); end
        checks++; if (tmr_fin_cuenta !== 32'd6) begin errors++; $display("FAIL fin_old_shadow: got %0d want 6", tmr_fin_cuenta); end
        rd(3'd1, 32'd12, "shadow_new");
        wait_sig(1'b1, n);
        checks++; if (tmr_fin_cuenta !== 32'd12) begin errors++; $display("FAIL fin_next: got %0d want 12", tmr_fin_cuenta); end
    endtask

    task automatic test_regs;
        int n;
        apply_reset;
        wr(3'd2, 32'd123);
        checks++; if (tmr_threshold !== 32'd123) begin errors++; $display("FAIL thr_direct: got %0d want 123", tmr_threshold); end
        rd(3'd2, 32'd123, "thr_read");
        wr(3'd6, 32'd55);
        rd(3'd6, 32'd0, "addr6_zero");
        rd(3'd7, 32'd0, "addr7_zero");
        wr(3'd0, 32'hFFFF_FFFE);
        rd(3'd0, 32'd6, "ctrl_upper_zero");
        wr(3'd1, 32'd100);
        wr(3'd0, 32'd1);
        for (n = 0; n < 50 && tmr_count !== 32'd7; n++) tick;
        checks++; if (n >= 50) begin errors++; $display("FAIL count_wait: tmr_count=%0d never reached 7", tmr_count); end
        rd(3'd4, 32'd7, "count_read");
        rd(3'd5, 32'd0, "addr5_zero");
    endtask

    task automatic test_period_zero;
        int k = 0;
        apply_reset;
        wr(3'd1, 32'd0);
        wr(3'd0, 32'd1);
        repeat (20) begin
            tick;
            if (tmr_borra_irq) k++;
        end
        checks++; if (k !== 10) begin errors++; $display("FAIL period0_events: got %0d want 10", k); end
    endtask

    task automatic test_async_reset;
        int n;
        apply_reset;
        wr(3'd1, 32'd3);
        wr(3'd0, 32'd5);
        rd(3'd1, 32'd3, "period_before_rst");
        wait_sig(1'b1, n);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tmr_enable !== 1'b0) begin errors++; $display("FAIL arst_enable: got %0b want 0", tmr_enable); end
        checks++; if (tmr_borra_irq !== 1'b0) begin errors++; $display("FAIL arst_borra: got %0b want 0", tmr_borra_irq); end
        checks++; if (tmr_fin_cuenta !== 32'd49999) begin errors++; $display("FAIL arst_fin: got %0d want 49999", tmr_fin_cuenta); end
        checks++; if (tmr_threshold !== 32'd24999) begin errors++; $display("FAIL arst_thr: got %0d want 24999", tmr_threshold); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL arst_irq: got %0b want 0", irq); end
        checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL arst_readdata: got %0h want 0", readdata); end
        @(negedge clk) rst_n = 1'b1;
        tick;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic;
        test_ovr;
        test_oneshot;
        test_period_update;
        test_regs;
        test_period_zero;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
